// File: rtl/sram_arbiter.sv
// Two-port (CPU read/write, video read-only) arbiter onto an asynchronous 8-bit SRAM.
// All strobes, address and write data are registered so the SRAM pins never glitch.
module sram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 3
) (
  input  logic              clk100,
  input  logic              reset_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_ack,
  output logic              RAMCS_b,
  output logic              RAMOE_b,
  output logic              RAMWE_b,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [7:0]        DAT
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_wdata_q, cpu_wdata_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              last_vid_q, last_vid_d;
  logic              gnt_vid_q, gnt_vid_d;
  logic              cs_q, cs_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              dat_oe_q, dat_oe_d;
  logic [7:0]        dat_out_q, dat_out_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              cpu_done, vid_done, pick_vid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_vid_d  = last_vid_q;
    gnt_vid_d   = gnt_vid_q;
    cs_d        = cs_q;
    oe_d        = oe_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_oe_d    = dat_oe_q;
    dat_out_d   = dat_out_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_done    = 1'b0;
    vid_done    = 1'b0;
    // Under contention video wins unless it took the previous grant.
    pick_vid    = vid_pend_q && (!cpu_pend_q || !last_vid_q);

    case (state_q)
      S_IDLE: begin
        if (cpu_pend_q || vid_pend_q) begin
          gnt_vid_d  = pick_vid;
          last_vid_d = pick_vid;
          cnt_d      = '0;
          cs_d       = 1'b0;
          adr_d      = pick_vid ? vid_addr_q : cpu_addr_q;
          if (pick_vid || !cpu_we_q) begin
            oe_d    = 1'b0;
            state_d = S_RD;
          end else begin
            dat_out_d = cpu_wdata_q;
            dat_oe_d  = 1'b1;
            state_d   = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          if (gnt_vid_q) begin
            vid_rdata_d = DAT;
            vid_ack_d   = 1'b1;
            vid_done    = 1'b1;
          end else begin
            cpu_rdata_d = DAT;
            cpu_ack_d   = 1'b1;
            cpu_done    = 1'b1;
          end
          cs_d    = 1'b1;
          oe_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        we_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          we_d    = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD: begin
        cs_d      = 1'b1;
        dat_oe_d  = 1'b0;
        cpu_ack_d = 1'b1;
        cpu_done  = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        cs_d     = 1'b1;
        oe_d     = 1'b1;
        we_d     = 1'b1;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // A request while the same port is still pending is dropped.
  always_comb begin
    cpu_pend_d  = cpu_pend_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    if (cpu_done) cpu_pend_d = 1'b0;
    if (vid_done) vid_pend_d = 1'b0;
    if (cpu_req && !cpu_pend_q) begin
      cpu_pend_d  = 1'b1;
      cpu_we_d    = cpu_we;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
    end
    if (vid_req && !vid_pend_q) begin
      vid_pend_d = 1'b1;
      vid_addr_d = vid_addr;
    end
  end

  always_ff @(posedge clk100 or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cpu_pend_q  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      last_vid_q  <= 1'b0;
      gnt_vid_q   <= 1'b0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      adr_q       <= '0;
      dat_oe_q    <= 1'b0;
      dat_out_q   <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      last_vid_q  <= last_vid_d;
      gnt_vid_q   <= gnt_vid_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_oe_q    <= dat_oe_d;
      dat_out_q   <= dat_out_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  assign DAT       = dat_oe_q ? dat_out_q : {8{1'bz}};
  assign RAMCS_b   = cs_q;
  assign RAMOE_b   = oe_q;
  assign RAMWE_b   = we_q;
  assign ADR       = adr_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, pin-protocol monitor, vector table,
// corner-case sequences and randomized accesses against a memory reference model.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW  = 18;
  localparam int RDC = 2;
  localparam int WRC = 3;

  logic          clk100 = 1'b0;
  logic          reset_b = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0]    vid_rdata;
  logic          vid_ack;
  logic          RAMCS_b, RAMOE_b, RAMWE_b;
  logic [AW-1:0] ADR;
  wire  [7:0]    DAT;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk100 = ~clk100;

  sram_arbiter #(.ADDR_W(AW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
    .clk100(clk100), .reset_b(reset_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .RAMCS_b(RAMCS_b), .RAMOE_b(RAMOE_b), .RAMWE_b(RAMWE_b), .ADR(ADR), .DAT(DAT)
  );

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ {6'd0, a[17:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // SRAM device: power-up contents from dflt(), writes latched on WE_b rising.
  // While deselected the bench holds the bus at 0, so any DUT drive shows up.
  logic [7:0] sram_w [int];
  logic [7:0] sram_rd = 8'h00;
  always @(negedge clk100)
    sram_rd = sram_w.exists(int'(ADR)) ? sram_w[int'(ADR)] : dflt(ADR);
  always @(posedge RAMWE_b)
    if (reset_b && !RAMCS_b) sram_w[int'(ADR)] = DAT;
  wire tb_drv = RAMCS_b | (~RAMOE_b & RAMWE_b);
  assign DAT = tb_drv ? (RAMCS_b ? 8'h00 : sram_rd) : 8'hzz;

  // Reference model: what memory should hold after the accesses the bench issued.
  logic [7:0] model_mem [int];
  function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : dflt(a);
  endfunction

  // Pin-protocol monitor: access lengths, stability, setup/hold, idle bus.
  int            run_len = 0, we_len = 0;
  bit            run_wr = 0, prev_we = 1;
  logic [AW-1:0] prev_adr = '0;
  logic [7:0]    prev_dat = '0;
  always @(negedge clk100) begin
    if (!mon_en || !reset_b) begin
      run_len = 0; we_len = 0; run_wr = 0; prev_we = 1;
    end else begin
      if (!RAMCS_b) begin
        if (run_len > 0) begin
          check("adr_stable", ADR, prev_adr);
          if (run_wr && RAMOE_b) check("dat_stable", DAT, prev_dat);
        end
        run_len++;
        if (RAMOE_b) run_wr = 1;
        if (!RAMWE_b) begin
          we_len++;
          check("we_setup", run_len > 1, 1);
        end
      end else begin
        if (run_len > 0) begin
          check("cs_run_len", run_len, run_wr ? WRC + 2 : RDC);
          check("we_pulse_len", we_len, run_wr ? WRC : 0);
          check("we_hold", prev_we, 1);
        end
        check("idle_strobes", {RAMOE_b, RAMWE_b}, 2'b11);
        check("idle_dat", DAT, 8'h00);
        run_len = 0; we_len = 0; run_wr = 0;
      end
      prev_we  = RAMWE_b;
      prev_adr = ADR;
      prev_dat = DAT;
    end
  end

  // Issue one request (called at a negedge) and measure cycles from the capture edge to ack.
  task automatic do_access(input bit vid, input bit we, input logic [AW-1:0] a,
                           input logic [7:0] wd, output logic [7:0] rd, output int lat);
    if (vid) begin
      vid_req = 1; vid_addr = a;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    @(posedge clk100);
    @(negedge clk100);
    cpu_req = 0; vid_req = 0;
    lat = 99; rd = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk100);
      @(negedge clk100);
      if (vid ? vid_ack : cpu_ack) begin
        lat = c;
        rd = vid ? vid_rdata : cpu_rdata;
        break;
      end
    end
    @(negedge clk100);
    check("ack_one_cycle", vid ? vid_ack : cpu_ack, 0);
  endtask

  typedef struct {
    bit            vid;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp;
  } vec_t;

  initial begin
    vec_t       vecs [10];
    logic [7:0] rd;
    int         lat, vlat, clat, acks;
    int         seq [$];
    bit         rv, rw;
    logic [AW-1:0] ra;
    logic [7:0]    rwd;

    vecs[0] = '{0, 1, 18'h000DE, 8'hA5, 8'h00};
    vecs[1] = '{0, 0, 18'h000DE, 8'h00, 8'hA5};
    vecs[2] = '{1, 0, 18'h1F000, 8'h00, dflt(18'h1F000)};
    vecs[3] = '{0, 1, 18'h00000, 8'h11, 8'h00};
    vecs[4] = '{0, 1, 18'h00001, 8'h22, 8'h00};
    vecs[5] = '{1, 0, 18'h00000, 8'h00, 8'h11};
    vecs[6] = '{1, 0, 18'h00001, 8'h00, 8'h22};
    vecs[7] = '{0, 0, 18'h000E0, 8'h00, dflt(18'h000E0)};
    vecs[8] = '{1, 0, 18'h000DE, 8'h00, 8'hA5};
    vecs[9] = '{0, 0, 18'h00001, 8'h00, 8'h22};

    #1 reset_b = 0;
    #3;
    check("rst_cs", RAMCS_b, 1);
    check("rst_oe", RAMOE_b, 1);
    check("rst_we", RAMWE_b, 1);
    check("rst_adr", ADR, 0);
    check("rst_acks", {cpu_ack, vid_ack}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_dat_hiz", DAT, 8'h00);
    repeat (2) @(negedge clk100);
    reset_b = 1;
    mon_en = 1;
    @(negedge clk100);

    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].vid, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].we ? WRC + 3 : RDC + 1);
      if (vecs[i].we) model_mem[int'(vecs[i].addr)] = vecs[i].wdata;
      else check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      $display("vec%0d vid=%0d we=%0d addr=0x%05h wd=0x%02h rd=0x%02h lat=%0d",
               i, vecs[i].vid, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
    end
    check("vid_rdata_held", vid_rdata, 8'hA5);

    // Simultaneous requests after a CPU grant: video first, CPU after one idle cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h000E0;
    vid_req = 1; vid_addr = 18'h1F000;
    @(posedge clk100);
    @(negedge clk100);
    cpu_req = 0; vid_req = 0;
    vlat = 99; clat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk100);
      @(negedge clk100);
      if (vid_ack && vlat == 99) vlat = c;
      if (cpu_ack && clat == 99) clat = c;
    end
    check("contend_vid_lat", vlat, RDC + 1);
    check("contend_cpu_lat", clat, 2 * RDC + 2);
    check("contend_cpu_rdata", cpu_rdata, model_rd(18'h000E0));
    check("contend_vid_rdata", vid_rdata, model_rd(18'h1F000));
    $display("contention vid_lat=%0d cpu_lat=%0d", vlat, clat);

    // Continuous contention, each port re-requesting in its own ack cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h000DE;
    vid_req = 1; vid_addr = 18'h1F000;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk100);
      @(negedge clk100);
      cpu_req = 0; vid_req = 0;
      if (vid_ack) begin seq.push_back(1); if (seq.size() < 8) vid_req = 1; end
      if (cpu_ack) begin seq.push_back(0); if (seq.size() < 8) cpu_req = 1; end
    end
    check("alt_count", seq.size() >= 8, 1);
    for (int k = 0; k < 8 && k < seq.size(); k++)
      check($sformatf("alt_grant%0d", k), seq[k], (k % 2 == 0) ? 1 : 0);
    $display("alternation grants=%0d first=%0d", seq.size(), seq.size() > 0 ? seq[0] : -1);

    // Duplicate CPU request while still pending.
    acks = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h000DE;
    @(posedge clk100); @(negedge clk100);
    cpu_req = 0; acks += int'(cpu_ack);
    @(posedge clk100); @(negedge clk100);
    cpu_req = 1; acks += int'(cpu_ack);
    @(posedge clk100); @(negedge clk100);
    cpu_req = 0; acks += int'(cpu_ack);
    repeat (15) begin
      @(posedge clk100); @(negedge clk100);
      acks += int'(cpu_ack);
    end
    check("dup_req_acks", acks, 1);
    check("dup_req_rdata", cpu_rdata, 8'hA5);
    $display("duplicate cpu_req acks=%0d", acks);

    // Reset in the middle of a write pulse.
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h03000; cpu_wdata = 8'h77;
    @(posedge clk100); @(negedge clk100);
    cpu_req = 0;
    for (int c = 0; c < 10 && RAMWE_b; c++) @(negedge clk100);
    check("abort_in_pulse", RAMWE_b, 0);
    mon_en = 0;
    #2 reset_b = 0;
    #1;
    check("abort_we", RAMWE_b, 1);
    check("abort_cs", RAMCS_b, 1);
    check("abort_oe", RAMOE_b, 1);
    check("abort_dat_hiz", DAT, 8'h00);
    acks = 0;
    repeat (3) begin
      @(negedge clk100);
      acks += int'(cpu_ack) + int'(vid_ack);
    end
    reset_b = 1;
    @(negedge clk100);
    acks += int'(cpu_ack) + int'(vid_ack);
    check("abort_no_ack", acks, 0);
    check("abort_adr", ADR, 0);
    check("abort_rdata", {cpu_rdata, vid_rdata}, 0);
    check("abort_strobes", {RAMCS_b, RAMOE_b, RAMWE_b}, 3'b111);
    mon_en = 1;
    do_access(0, 0, 18'h000DE, 8'h00, rd, lat);
    check("post_reset_lat", lat, RDC + 1);
    check("post_reset_rdata", rd, 8'hA5);
    $display("reset abort acks=%0d post_read=0x%02h lat=%0d", acks, rd, lat);

    // Randomized single accesses against the reference model.
    for (int n = 0; n < 30; n++) begin
      rv  = 1'($urandom_range(0, 1));
      rw  = rv ? 1'b0 : 1'($urandom_range(0, 1));
      ra  = 18'h02000 + AW'($urandom_range(0, 15));
      rwd = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk100);
      do_access(rv, rw, ra, rwd, rd, lat);
      check($sformatf("rnd%0d_lat", n), lat, rw ? WRC + 3 : RDC + 1);
      if (rw) model_mem[int'(ra)] = rwd;
      else check($sformatf("rnd%0d_rdata", n), rd, model_rd(ra));
      $display("rnd%0d vid=%0d we=%0d addr=0x%05h wd=0x%02h rd=0x%02h lat=%0d",
               n, rv, rw, ra, rwd, rd, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
